// File: rtl/dmem_arbiter_if.sv
// Bus between the two L2 requesters, the data-memory arbiter and the memory port.
// The master side drives requests and memory read data; the slave side is the arbiter.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [1:0]        req_i;
    logic [1:0]        we_i;
    logic [ADDR_W-1:0] addr0_i;
    logic [ADDR_W-1:0] addr1_i;
    logic [DATA_W-1:0] wdata0_i;
    logic [DATA_W-1:0] wdata1_i;
    logic [1:0]        gnt_o;
    logic [1:0]        rvalid_o;
    logic [DATA_W-1:0] rdata_o;
    logic              busy_o;
    logic [6:0]        mem_opcode_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic [DATA_W-1:0] mem_rdata_i;

    modport master (
        output req_i, we_i, addr0_i, addr1_i, wdata0_i, wdata1_i, mem_rdata_i,
        input  gnt_o, rvalid_o, rdata_o, busy_o, mem_opcode_o, mem_addr_o, mem_wdata_o
    );

    modport slave (
        input  req_i, we_i, addr0_i, addr1_i, wdata0_i, wdata1_i, mem_rdata_i,
        output gnt_o, rvalid_o, rdata_o, busy_o, mem_opcode_o, mem_addr_o, mem_wdata_o
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-requester round-robin data-memory arbiter: IDLE -> ACCESS (MEM_LAT cycles) -> RESP.
// All outputs are registered; requests are only sampled in IDLE and never queued.
module dmem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic          clk,
    input  logic          reset,
    dmem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [3:0] LAT_LAST = 4'(MEM_LAT - 1);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              win_q, win_d;
    logic              last_gnt_q, last_gnt_d;
    logic [1:0]        gnt_q, gnt_d;
    logic [1:0]        rvalid_q, rvalid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              busy_q, busy_d;
    logic [6:0]        op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              sel_w;

    // A lone request wins outright; on a tie the requester that did not win last time goes.
    function automatic logic pick(input logic [1:0] req, input logic last);
        logic w;
        case (req)
            2'b01:   w = 1'b0;
            2'b10:   w = 1'b1;
            default: w = ~last;
        endcase
        return w;
    endfunction

    function automatic logic [1:0] onehot(input logic w);
        return w ? 2'b10 : 2'b01;
    endfunction

    assign sel_w = pick(bus.req_i, last_gnt_q);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        win_d      = win_q;
        last_gnt_d = last_gnt_q;
        gnt_d      = 2'b00;
        rvalid_d   = 2'b00;
        rdata_d    = rdata_q;
        op_d       = op_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        case (state_q)
            IDLE: begin
                if (bus.req_i != 2'b00) begin
                    win_d      = sel_w;
                    last_gnt_d = sel_w;
                    gnt_d      = onehot(sel_w);
                    cnt_d      = 4'd0;
                    op_d       = (sel_w ? bus.we_i[1] : bus.we_i[0]) ? OP_STORE : OP_LOAD;
                    addr_d     = {(sel_w ? bus.addr1_i[ADDR_W-1:2] : bus.addr0_i[ADDR_W-1:2]), 2'b00};
                    wdata_d    = sel_w ? bus.wdata1_i : bus.wdata0_i;
                    state_d    = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q == LAT_LAST) begin
                    // Stores complete with a zero result so rdata never shows stale load data.
                    rdata_d  = (op_q == OP_STORE) ? '0 : bus.mem_rdata_i;
                    rvalid_d = onehot(win_q);
                    op_d     = 7'd0;
                    addr_d   = '0;
                    wdata_d  = '0;
                    state_d  = RESP;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            win_q      <= 1'b0;
            last_gnt_q <= 1'b1;
            gnt_q      <= 2'b00;
            rvalid_q   <= 2'b00;
            rdata_q    <= '0;
            busy_q     <= 1'b0;
            op_q       <= 7'd0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            win_q      <= win_d;
            last_gnt_q <= last_gnt_d;
            gnt_q      <= gnt_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            busy_q     <= busy_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
        end
    end

    assign bus.gnt_o        = gnt_q;
    assign bus.rvalid_o     = rvalid_q;
    assign bus.rdata_o      = rdata_q;
    assign bus.busy_o       = busy_q;
    assign bus.mem_opcode_o = op_q;
    assign bus.mem_addr_o   = addr_q;
    assign bus.mem_wdata_o  = wdata_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: one instance with MEM_LAT=1, one with MEM_LAT=3.
// Stimulus pushes hand-computed grant/response expectations; negedge monitors pop and compare.
module tb_dmem_arbiter;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    logic clk  = 1'b0;
    logic rst1 = 1'b1;
    logic rst3 = 1'b1;
    int   cyc  = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    int   opcnt3 = 0;

    typedef struct {
        logic [1:0]  oh;
        logic [6:0]  op;
        logic [31:0] addr;
        logic [31:0] dat;
        int          cyc;
    } exp_t;

    exp_t gq1[$];
    exp_t rq1[$];
    exp_t gq3[$];
    exp_t rq3[$];

    dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) if1 ();
    dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) if3 ();

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u_dut1 (.clk(clk), .reset(rst1), .bus(if1.slave));
    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3)) u_dut3 (.clk(clk), .reset(rst3), .bus(if3.slave));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    task automatic chk_zero(input string t, input logic [1:0] g, input logic [1:0] r,
                            input logic [31:0] rd, input logic b, input logic [6:0] op,
                            input logic [31:0] a, input logic [31:0] wd);
        chk({t, "_gnt"}, g, 0);
        chk({t, "_rvalid"}, r, 0);
        chk({t, "_rdata"}, rd, 0);
        chk({t, "_busy"}, b, 0);
        chk({t, "_opcode"}, op, 0);
        chk({t, "_addr"}, a, 0);
        chk({t, "_wdata"}, wd, 0);
    endtask

    always @(negedge clk) begin : mon1
        exp_t e;
        if (if1.gnt_o != 2'b00) begin
            if (gq1.size() == 0) chk("d1_unexpected_gnt", if1.gnt_o, 0);
            else begin
                e = gq1.pop_front();
                chk("d1_gnt", if1.gnt_o, e.oh);
                chk("d1_gnt_cycle", cyc, e.cyc);
                chk("d1_opcode", if1.mem_opcode_o, e.op);
                chk("d1_mem_addr", if1.mem_addr_o, e.addr);
                chk("d1_mem_wdata", if1.mem_wdata_o, e.dat);
                chk("d1_gnt_rvalid_excl", if1.rvalid_o, 0);
            end
        end
        if (if1.rvalid_o != 2'b00) begin
            if (rq1.size() == 0) chk("d1_unexpected_rvalid", if1.rvalid_o, 0);
            else begin
                e = rq1.pop_front();
                chk("d1_rvalid", if1.rvalid_o, e.oh);
                chk("d1_rvalid_cycle", cyc, e.cyc);
                chk("d1_rdata", if1.rdata_o, e.dat);
                chk("d1_resp_opcode", if1.mem_opcode_o, 0);
            end
        end
    end

    always @(negedge clk) begin : mon3
        exp_t e;
        if (rst3) opcnt3 = 0;
        else if (if3.mem_opcode_o != 7'd0) opcnt3++;
        if (if3.gnt_o != 2'b00) begin
            if (gq3.size() == 0) chk("d3_unexpected_gnt", if3.gnt_o, 0);
            else begin
                e = gq3.pop_front();
                chk("d3_gnt", if3.gnt_o, e.oh);
                chk("d3_gnt_cycle", cyc, e.cyc);
                chk("d3_opcode", if3.mem_opcode_o, e.op);
                chk("d3_mem_addr", if3.mem_addr_o, e.addr);
                chk("d3_mem_wdata", if3.mem_wdata_o, e.dat);
            end
        end
        if (if3.rvalid_o != 2'b00) begin
            if (rq3.size() == 0) chk("d3_unexpected_rvalid", if3.rvalid_o, 0);
            else begin
                e = rq3.pop_front();
                chk("d3_rvalid", if3.rvalid_o, e.oh);
                chk("d3_rvalid_cycle", cyc, e.cyc);
                chk("d3_rdata", if3.rdata_o, e.dat);
                chk("d3_access_cycles", opcnt3, 3);
                chk("d3_gnt_rvalid_excl", if3.gnt_o, 0);
            end
            opcnt3 = 0;
        end
    end

    task automatic wait_gnt1(input int i);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (if1.gnt_o[i]) return;
        end
        chk("d1_gnt_timeout", 0, 1);
    endtask

    task automatic wait_gnt3(input int i);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (if3.gnt_o[i]) return;
        end
        chk("d3_gnt_timeout", 0, 1);
    endtask

    initial begin : stim
        int e0;
        {if1.req_i, if1.we_i, if1.addr0_i, if1.addr1_i, if1.wdata0_i, if1.wdata1_i, if1.mem_rdata_i} = '0;
        {if3.req_i, if3.we_i, if3.addr0_i, if3.addr1_i, if3.wdata0_i, if3.wdata1_i, if3.mem_rdata_i} = '0;
        repeat (3) @(negedge clk);
        chk_zero("d1_rst", if1.gnt_o, if1.rvalid_o, if1.rdata_o, if1.busy_o, if1.mem_opcode_o, if1.mem_addr_o, if1.mem_wdata_o);
        chk_zero("d3_rst", if3.gnt_o, if3.rvalid_o, if3.rdata_o, if3.busy_o, if3.mem_opcode_o, if3.mem_addr_o, if3.mem_wdata_o);
        rst1 = 1'b0;
        rst3 = 1'b0;

        // Single load, MEM_LAT=1
        @(negedge clk);
        if1.req_i = 2'b01; if1.we_i = 2'b00; if1.addr0_i = 32'hE; if1.mem_rdata_i = 32'h4;
        e0 = cyc + 1;
        gq1.push_back('{2'b01, OP_LOAD, 32'hC, 32'h0, e0});
        rq1.push_back('{2'b01, 7'd0, 32'h0, 32'h4, e0 + 1});
        wait_gnt1(0);
        if1.req_i = 2'b00;
        repeat (4) @(negedge clk);
        chk("d1_rdata_hold", if1.rdata_o, 32'h4);

        // Tie straight after reset: core0 store first, then core1 load
        rst1 = 1'b1;
        repeat (2) @(negedge clk);
        rst1 = 1'b0;
        if1.req_i = 2'b11; if1.we_i = 2'b01;
        if1.addr0_i = 32'h10; if1.wdata0_i = 32'hAA; if1.addr1_i = 32'h20; if1.wdata1_i = 32'h0;
        if1.mem_rdata_i = 32'h1234;
        e0 = cyc + 1;
        gq1.push_back('{2'b01, OP_STORE, 32'h10, 32'hAA, e0});
        rq1.push_back('{2'b01, 7'd0, 32'h0, 32'h0, e0 + 1});
        gq1.push_back('{2'b10, OP_LOAD, 32'h20, 32'h0, e0 + 3});
        rq1.push_back('{2'b10, 7'd0, 32'h0, 32'h1234, e0 + 4});
        wait_gnt1(0);
        if1.req_i = 2'b10;
        wait_gnt1(1);
        if1.req_i = 2'b00;
        repeat (4) @(negedge clk);

        // Six back-to-back transactions with both requesting continuously
        if1.req_i = 2'b11; if1.we_i = 2'b00;
        if1.addr0_i = 32'h100; if1.addr1_i = 32'h207; if1.wdata0_i = 32'h0; if1.mem_rdata_i = 32'h77;
        e0 = cyc + 1;
        for (int k = 0; k < 6; k++) begin
            gq1.push_back('{(k % 2) ? 2'b10 : 2'b01, OP_LOAD, (k % 2) ? 32'h204 : 32'h100, 32'h0, e0 + 3 * k});
            rq1.push_back('{(k % 2) ? 2'b10 : 2'b01, 7'd0, 32'h0, 32'h77, e0 + 3 * k + 1});
        end
        for (int t = 0; t < 16; t++) begin
            @(negedge clk);
            chk("d1_busy_pattern", if1.busy_o, (t % 3) != 2);
            if (t == 15) if1.req_i = 2'b00;
        end
        repeat (4) @(negedge clk);

        // MEM_LAT=3 single load
        if3.req_i = 2'b01; if3.we_i = 2'b00; if3.addr0_i = 32'h30; if3.mem_rdata_i = 32'h99;
        e0 = cyc + 1;
        gq3.push_back('{2'b01, OP_LOAD, 32'h30, 32'h0, e0});
        rq3.push_back('{2'b01, 7'd0, 32'h0, 32'h99, e0 + 3});
        wait_gnt3(0);
        if3.req_i = 2'b00;
        repeat (5) @(negedge clk);

        // Requests and addresses change during ACCESS
        if3.req_i = 2'b01; if3.addr0_i = 32'h40; if3.mem_rdata_i = 32'h5A;
        e0 = cyc + 1;
        gq3.push_back('{2'b01, OP_LOAD, 32'h40, 32'h0, e0});
        rq3.push_back('{2'b01, 7'd0, 32'h0, 32'h5A, e0 + 3});
        wait_gnt3(0);
        if3.req_i = 2'b10; if3.addr0_i = 32'h99; if3.addr1_i = 32'h80;
        @(negedge clk);
        chk("d3_addr_hold_a", if3.mem_addr_o, 32'h40);
        if3.req_i = 2'b11;
        @(negedge clk);
        chk("d3_addr_hold_b", if3.mem_addr_o, 32'h40);
        if3.req_i = 2'b00;
        repeat (5) @(negedge clk);

        // Reset in the second ACCESS cycle aborts; next tie goes to core0
        if3.req_i = 2'b01; if3.addr0_i = 32'h50;
        e0 = cyc + 1;
        gq3.push_back('{2'b01, OP_LOAD, 32'h50, 32'h0, e0});
        wait_gnt3(0);
        if3.req_i = 2'b00;
        @(negedge clk);
        rst3 = 1'b1;
        @(negedge clk);
        chk_zero("d3_abort", if3.gnt_o, if3.rvalid_o, if3.rdata_o, if3.busy_o, if3.mem_opcode_o, if3.mem_addr_o, if3.mem_wdata_o);
        @(negedge clk);
        rst3 = 1'b0;
        if3.req_i = 2'b11; if3.we_i = 2'b00; if3.addr0_i = 32'h60; if3.addr1_i = 32'h70; if3.mem_rdata_i = 32'h33;
        e0 = cyc + 1;
        gq3.push_back('{2'b01, OP_LOAD, 32'h60, 32'h0, e0});
        rq3.push_back('{2'b01, 7'd0, 32'h0, 32'h33, e0 + 3});
        gq3.push_back('{2'b10, OP_LOAD, 32'h70, 32'h0, e0 + 5});
        rq3.push_back('{2'b10, 7'd0, 32'h0, 32'h33, e0 + 8});
        wait_gnt3(0);
        if3.req_i = 2'b10;
        wait_gnt3(1);
        if3.req_i = 2'b00;

        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (gq1.size() + rq1.size() + gq3.size() + rq3.size() == 0) break;
        end
        @(negedge clk);
        chk("leftover_expectations", gq1.size() + rq1.size() + gq3.size() + rq3.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
